pipe_mem_arbiter: RTL and testbench

//  Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
//  It sits between pipeif/pipemem and the memory macro and serialises their accesses.
//  It inserts WAIT_CYCLES memory wait states per access and produces per-stage stall signals that hold the PC and the pipeline registers.

---
 rtl/pipe_mem_pkg.sv | 14 +
 rtl/pipe_mem_waitcnt.sv | 26 ++
 rtl/pipe_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
// FSM state encodings and grant identifiers.
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/pipe_mem_waitcnt.sv
// Loadable 4-bit down-counter timing the memory wait states.
// Saturates at zero; zero flag drives the ACCESS exit.
module pipe_mem_waitcnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one memory port.
// Each access holds mem_en for WAIT_CYCLES, then pulses ready once.
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be within 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_nx;
  logic              gnt;
  logic              take;
  logic              sel_d;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              in_access;
  logic              in_resp;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  pipe_mem_waitcnt u_waitcnt (
    .clock (clock),
    .reset (reset),
    .load  (take),
    .value (CNT_LOAD),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    sel_d    = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (if_req || d_req) begin
          take     = 1'b1;
          state_nx = ST_ACCESS;
          // D wins ties unless it had the previous grant
          sel_d    = d_req && (!if_req || gnt != GNT_D);
        end
      end
      ST_ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_nx = ST_RESP;
      end
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        gnt     <= sel_d ? GNT_D : GNT_IF;
        we_q    <= sel_d && d_we;
        addr_q  <= sel_d ? d_addr : if_addr;
        wdata_q <= sel_d ? d_wdata : '0;
      end
      if (in_access && cnt_zero) begin
        if (gnt == GNT_D) d_rdata_q  <= mem_rdata;
        else              if_rdata_q <= mem_rdata;
      end
    end
  end

  assign in_access = (state == ST_ACCESS);
  assign in_resp   = (state == ST_RESP);

  assign mem_en    = in_access;
  assign mem_we    = in_access && we_q;
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  assign if_ready  = in_resp && (gnt == GNT_IF);
  assign d_ready   = in_resp && (gnt == GNT_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall_if  = if_req && !if_ready;
  assign stall_d   = d_req && !d_ready;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: directed cases then random
// traffic from two independent requesters against a word memory.
module tb_pipe_mem_arbiter;

  localparam int W = 2;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        if_req, if_ready, d_req, d_we, d_ready;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, stall_if, stall_d;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_reset;
  logic        b_if_req, b_if_ready, b_d_req, b_d_we, b_d_ready;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic        b_mem_en, b_mem_we, b_stall_if, b_stall_d;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [31:0] mem  [0:255];
  logic [31:0] dref [0:255];

  assign mem_rdata   = mem[mem_addr[9:2]];
  assign b_mem_rdata = mem[b_mem_addr[9:2]];

  always @(posedge clock) if (mem_we) mem[mem_addr[9:2]] = mem_wdata;

  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_d(stall_d)
  );

  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
    .clock(clock), .reset(b_reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_ready(b_if_ready),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .stall_if(b_stall_if), .stall_d(b_stall_d)
  );

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic [31:0] exp_if [$];
  exp_t        exp_d  [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: invariants every cycle, arbitration order, scoreboard pops
  int   cyc = 0;
  int   rise_cyc = 0;
  bit   arb_on = 1'b0;
  logic prev_en = 1'b0, prev_if = 1'b0, prev_d = 1'b0;
  logic tb_last = 1'b0;

  always @(negedge clock) begin
    logic g, eg;
    exp_t e;
    cyc++;
    chk1("one_ready", if_ready & d_ready, 1'b0);
    chk1("we_needs_en", mem_we & ~mem_en, 1'b0);
    chk1("stall_if", stall_if, if_req & ~if_ready);
    chk1("stall_d", stall_d, d_req & ~d_ready);
    if (reset) tb_last = 1'b0;
    if (mem_en && !prev_en) begin
      rise_cyc = cyc;
      if (arb_on) begin
        g  = (mem_addr >= 32'h200);
        eg = (prev_if && prev_d) ? ~tb_last : prev_d;
        chk1("arb_grant", g, eg);
        tb_last = g;
      end
    end
    if (if_ready) begin
      chk("if_latency", cyc - rise_cyc, W);
      chk1("if_sb_has_exp", exp_if.size() > 0, 1'b1);
      if (exp_if.size() > 0) chk("if_rdata", if_rdata, exp_if.pop_front());
    end
    if (d_ready) begin
      chk("d_latency", cyc - rise_cyc, W);
      chk1("d_sb_has_exp", exp_d.size() > 0, 1'b1);
      if (exp_d.size() > 0) begin
        e = exp_d.pop_front();
        if (e.chk) chk("d_rdata", d_rdata, e.data);
      end
    end
    prev_en = mem_en;
    prev_if = if_req;
    prev_d  = d_req;
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; b_reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; b_reset = 1'b0;
    @(negedge clock);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_ready", if_ready | d_ready, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_b_out", b_mem_en | b_mem_we | b_if_ready | b_d_ready, 1'b0);
    chk("rst_b_data", b_if_rdata | b_d_rdata | b_mem_wdata, 32'h0);
    nxt();
  endtask

  task automatic if_drv();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int t;
      bit done;
      repeat ($urandom_range(0, 3)) nxt();
      a = 32'($urandom_range(0, 127)) << 2;
      if_addr = a;
      exp_if.push_back(mem[a[9:2]]);
      if_req = 1'b1;
      t = 0; done = 1'b0;
      while (!done && t < 100) begin
        @(negedge clock);
        if (if_ready) done = 1'b1;
        t++;
      end
      chk1("if_done_in_time", done, 1'b1);
      nxt();
      if_req = 1'b0;
    end
  endtask

  task automatic d_drv();
    for (int i = 0; i < 40; i++) begin
      int idx, t;
      bit done;
      exp_t e;
      repeat ($urandom_range(0, 3)) nxt();
      idx = 128 + $urandom_range(0, 127);
      d_addr  = 32'(idx) << 2;
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      if (d_we) begin
        dref[idx] = d_wdata;
        e.chk = 1'b0; e.data = '0;
      end else begin
        e.chk = 1'b1; e.data = dref[idx];
      end
      exp_d.push_back(e);
      d_req = 1'b1;
      t = 0; done = 1'b0;
      while (!done && t < 100) begin
        @(negedge clock);
        if (d_ready) done = 1'b1;
        t++;
      end
      chk1("d_done_in_time", done, 1'b1);
      nxt();
      d_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrdy;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A50000;
    mem[1]  = 32'h8C010080;
    mem[2]  = 32'h12345678;
    mem[32] = 32'h0;
    mem[33] = 32'h1F;
    b_if_req = 1'b0; b_if_addr = '0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;

    // Fetch
    do_reset();
    if_req = 1'b1; if_addr = 32'h4;
    exp_if.push_back(32'h8C010080);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk1("t1_mem_en", mem_en, k == 1 || k == 2);
      chk1("t1_stall_if", stall_if, k <= 2);
      chk1("t1_if_ready", if_ready, k == 3);
      if (k == 3) chk("t1_if_rdata", if_rdata, 32'h8C010080);
      nxt();
    end
    if_req = 1'b0;

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h55;
    exp_d.push_back('{chk: 1'b0, data: 32'h0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk1("t2_mem_we", mem_we, k == 1 || k == 2);
      chk1("t2_d_ready", d_ready, k == 3);
      chk1("t2_if_ready", if_ready, 1'b0);
      nxt();
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clock);
    chk("t2_mem_written", mem[32], 32'h55);

    // Tie: D first, then IF
    do_reset();
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_addr = 32'h80;
    exp_d.push_back('{chk: 1'b1, data: 32'h55});
    exp_if.push_back(32'h12345678);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk1("t3_d_ready", d_ready, k == 3);
      chk1("t3_if_ready", if_ready, k == 7);
      chk1("t3_mem_en", mem_en, k == 1 || k == 2 || k == 5 || k == 6);
      nxt();
      if (k == 3) d_req = 1'b0;
    end
    if_req = 1'b0;

    // Fairness with both held high
    do_reset();
    if_req = 1'b1; if_addr = 32'h4;
    d_req = 1'b1; d_addr = 32'h80;
    for (int i = 0; i < 2; i++) begin
      exp_d.push_back('{chk: 1'b1, data: 32'h55});
      exp_if.push_back(32'h8C010080);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      chk1("t4_d_ready", d_ready, k == 3 || k == 11);
      chk1("t4_if_ready", if_ready, k == 7 || k == 15);
      nxt();
    end
    if_req = 1'b0; d_req = 1'b0;

    // Reset mid-access
    do_reset();
    d_req = 1'b1; d_addr = 32'h84;
    nxt();
    reset = 1'b1; d_req = 1'b0;
    @(negedge clock);
    chk1("t5_in_access", mem_en, 1'b1);
    nxt();
    reset = 1'b0;
    @(negedge clock);
    chk1("t5_mem_en", mem_en, 1'b0);
    chk1("t5_mem_we", mem_we, 1'b0);
    chk("t5_mem_addr", mem_addr, 32'h0);
    chk1("t5_stall_d", stall_d, 1'b0);
    chk("t5_d_rdata", d_rdata, 32'h0);
    nrdy = 0;
    for (int k = 0; k < 8; k++) begin
      nxt();
      @(negedge clock);
      if (if_ready || d_ready) nrdy++;
    end
    chk("t5_no_ready", nrdy, 0);
    nxt();

    // WAIT_CYCLES=1 instance
    b_d_req = 1'b1; b_d_addr = 32'h84;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk1("t6_mem_en", b_mem_en, k == 1);
      chk1("t6_mem_we", b_mem_we, 1'b0);
      chk1("t6_d_ready", b_d_ready, k == 2);
      chk1("t6_stall_d", b_stall_d, k < 2);
      chk1("t6_if_side", b_if_ready | b_stall_if, 1'b0);
      if (k == 2) chk("t6_d_rdata", b_d_rdata, 32'h1F);
      nxt();
    end
    b_d_req = 1'b0;

    // Random traffic
    do_reset();
    for (int i = 0; i < 256; i++) dref[i] = mem[i];
    arb_on = 1'b1;
    fork
      if_drv();
      d_drv();
    join
    repeat (10) nxt();
    arb_on = 1'b0;
    chk("sb_if_drained", exp_if.size(), 0);
    chk("sb_d_drained", exp_d.size(), 0);
    for (int i = 128; i < 256; i++)
      if (mem[i] !== dref[i]) chk("rnd_mem_final", mem[i], dref[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
